// File: rtl/rr_arbiter_lock_if.sv
// Handshake bundle between N packet sources and the round-robin lock arbiter.
//   req       : per-requester request, held for the whole packet
//   last      : per-requester final-beat flag
//   ack       : downstream accepts the current beat
//   gnt       : registered one-hot grant (zero when idle)
//   gnt_valid : |gnt
//   gnt_id    : binary index of the granted requester (0 when idle)
//   timeout   : one-cycle pulse on forced release
// Modports: master = requester/downstream side, slave = arbiter side.
interface rr_arbiter_lock_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic           ack;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;

    modport master (
        output req, last, ack,
        input  gnt, gnt_valid, gnt_id, timeout
    );

    modport slave (
        input  req, last, ack,
        output gnt, gnt_valid, gnt_id, timeout
    );
endinterface

// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter with grant locking for multi-beat packets.
// A winner keeps its grant until its final beat (req & last & ack) or until it drops req;
// on release the next winner is chosen in the same cycle, so there is no idle bubble.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   arb_io : rr_arbiter_lock_if.slave (req/last/ack in, gnt/gnt_valid/gnt_id/timeout out)
// Optional feature: define RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles of
// holding; otherwise timeout is tied low and there is no hold counter.
module rr_arbiter_lock #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst,
    rr_arbiter_lock_if.slave   arb_io
);
    localparam int unsigned IDW = $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("rr_arbiter_lock: N must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_arbiter_lock: MAX_HOLD must be >= 2");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] gnt_id_q;
    logic [IDW-1:0] ptr_q;

    logic [IDW-1:0] arb_ptr;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] hi_idx;
    logic           hi_any;
    logic [N-1:0]   win_onehot;
    logic           req_w;
    logic           rel;
    logic           force_rel;

    // Winner search. While busy the pointer used is the current winner, which is what ptr
    // becomes on release, so the same result serves both idle and back-to-back arbitration.
    always_comb begin
        arb_ptr = (state_q == StBusy) ? gnt_id_q : ptr_q;
        win_idx = '0;
        hi_idx  = '0;
        hi_any  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (arb_io.req[i]) begin
                win_idx = IDW'(i);
            end
            if (arb_io.req[i] && (i > int'(arb_ptr))) begin
                hi_idx = IDW'(i);
                hi_any = 1'b1;
            end
        end
        if (hi_any) begin
            win_idx = hi_idx;
        end
        win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
        req_w      = arb_io.req[gnt_id_q];
        rel        = (req_w & arb_io.ack & arb_io.last[gnt_id_q]) | ~req_w;
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

    logic [HCW-1:0] hold_cnt_q;
    logic           timeout_q;

    assign force_rel      = (hold_cnt_q == HCW'(MAX_HOLD - 1)) & ~rel;
    assign arb_io.timeout = timeout_q;
`else
    assign force_rel      = 1'b0;
    assign arb_io.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= IDW'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (|arb_io.req) begin
                        state_q  <= StBusy;
                        gnt_q    <= win_onehot;
                        gnt_id_q <= win_idx;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (rel || force_rel) begin
                        ptr_q <= gnt_id_q;
`ifdef RR_ARB_TIMEOUT_EN
                        timeout_q  <= force_rel;
                        hold_cnt_q <= '0;
`endif
                        if (|arb_io.req) begin
                            gnt_q    <= win_onehot;
                            gnt_id_q <= win_idx;
                        end else begin
                            state_q  <= StIdle;
                            gnt_q    <= '0;
                            gnt_id_q <= '0;
                        end
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        if (hold_cnt_q != '1) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign arb_io.gnt       = gnt_q;
    assign arb_io.gnt_valid = |gnt_q;
    assign arb_io.gnt_id    = gnt_id_q;
endmodule
